// File: rtl/core_ex_muldiv.sv
// core_ex_muldiv: iterative MUL/DIV unit with HI/LO registers; signed/unsigned, word and doubleword forms.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
`default_nettype none
`timescale 1ns/1ps

module core_ex_muldiv #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_mthi,
  input  logic            i_mtlo,
  input  logic            i_read_hilo,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_stall
);

  localparam int DW     = 2 * XLEN;
  localparam int CW     = 7;
  localparam int N_WORD = 32 / BITS_PER_CYCLE;
  localparam int N_FULL = XLEN / BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t          r_state, w_next;
  logic            r_is_div, r_word, r_neg_q, r_neg_r, r_dz, r_done;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_acc, r_md;
  logic [XLEN-1:0] r_q, r_hi, r_lo;
  logic [XLEN:0]   r_rem;

  function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] f_zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  // Operand preparation: the word flag only matters when the datapath is wider than 32 bits.
  logic            w_word, w_signed, w_div, w_accept, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;

  always_comb begin
    w_word   = (XLEN > 32) ? i_word : 1'b0;
    w_signed = ~i_op[0];
    w_div    = i_op[1];
    if (w_word) begin
      w_a_ext = w_signed ? f_sext32(i_a[31:0]) : f_zext32(i_a[31:0]);
      w_b_ext = w_signed ? f_sext32(i_b[31:0]) : f_zext32(i_b[31:0]);
    end else begin
      w_a_ext = i_a;
      w_b_ext = i_b;
    end
    w_a_neg  = w_signed & w_a_ext[XLEN-1];
    w_b_neg  = w_signed & w_b_ext[XLEN-1];
    w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    w_accept = (r_state == S_IDLE) & i_start & ~i_flush & ~i_mthi & ~i_mtlo;
  end

  // One RUN iteration: shift-add multiply or chained restoring divide stages.
  logic [DW-1:0]   w_acc_nx, w_md_nx;
  logic [XLEN-1:0] w_q_nx;
  logic [XLEN:0]   w_rem_nx;

  always_comb begin
    w_acc_nx = r_acc;
    w_md_nx  = r_md;
    w_q_nx   = r_q;
    w_rem_nx = r_rem;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_is_div) begin
        w_rem_nx = {w_rem_nx[XLEN-1:0], w_q_nx[XLEN-1]};
        w_q_nx   = {w_q_nx[XLEN-2:0], 1'b0};
        if (w_rem_nx >= {1'b0, r_md[XLEN-1:0]}) begin
          w_rem_nx  = w_rem_nx - {1'b0, r_md[XLEN-1:0]};
          w_q_nx[0] = 1'b1;
        end
      end else if (r_q[i]) begin
        w_acc_nx = w_acc_nx + (r_md << i);
      end
    end
    if (!r_is_div) begin
      w_md_nx = r_md << BITS_PER_CYCLE;
      w_q_nx  = r_q >> BITS_PER_CYCLE;
    end
  end

  logic w_last, w_early;

  always_comb begin
    w_last = r_word ? (r_cnt == CW'(N_WORD - 1)) : (r_cnt == CW'(N_FULL - 1));
`ifdef MULDIV_EARLY_OUT_EN
    w_early = ~r_is_div & (w_q_nx == '0);
`else
    w_early = 1'b0;
`endif
  end

  // Sign correction and result formatting for the FIX write.
  logic [DW-1:0]   w_prod;
  logic [XLEN-1:0] w_quo, w_rmd, w_res_hi, w_res_lo;

  always_comb begin
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quo  = r_neg_q ? -r_q : r_q;
    w_rmd  = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    if (!r_is_div) begin
      w_res_hi = w_prod[DW-1:XLEN];
      w_res_lo = w_prod[XLEN-1:0];
    end else if (r_dz) begin
      w_res_hi = r_acc[XLEN-1:0];
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rmd;
      w_res_lo = w_quo;
    end
    if (r_word) begin
      if (!r_is_div) begin
        w_res_hi = f_sext32(w_prod[63:32]);
        w_res_lo = f_sext32(w_prod[31:0]);
      end else begin
        w_res_hi = f_sext32(w_res_hi[31:0]);
        w_res_lo = f_sext32(w_res_lo[31:0]);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (i_flush) w_next = S_IDLE;
               else if (w_last | w_early) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_word   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_md     <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mthi) r_hi <= i_a;
          if (i_mtlo) r_lo <= i_a;
          if (w_accept) begin
            r_is_div <= w_div;
            r_word   <= w_word;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (w_b_ext == '0);
            r_cnt    <= '0;
            r_rem    <= '0;
            r_md     <= DW'(w_div ? w_b_mag : w_a_mag);
            // Divide keeps the raw dividend in the accumulator for the divide-by-zero result.
            r_acc    <= w_div ? DW'(w_a_ext) : '0;
            if (w_div) r_q <= w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
            else       r_q <= w_b_mag;
          end
        end
        S_RUN: begin
          if (!i_flush) begin
            r_acc <= w_acc_nx;
            r_md  <= w_md_nx;
            r_q   <= w_q_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!i_flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_done  = r_done;
  assign o_busy  = (r_state != S_IDLE);
  assign o_stall = o_busy & (i_start | i_read_hilo | i_mthi | i_mtlo);

endmodule

`default_nettype wire

// File: tb/tb_core_ex_muldiv.sv
// Scoreboard bench for core_ex_muldiv (XLEN=64, BITS_PER_CYCLE 1 and 4), directed vectors.
`default_nettype none
`timescale 1ns/1ps

module tb_core_ex_muldiv;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, word, mthi, mtlo, read_hilo, flush;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [63:0] hi, lo;
  logic        busy, done, stall;

  logic        s4_start;
  logic [1:0]  s4_op;
  logic        s4_word;
  logic [63:0] s4_a, s4_b;
  logic [63:0] d4_hi, d4_lo;
  logic        d4_busy, d4_done, d4_stall;
  logic        s4_zero = 1'b0;

  always #5 clk = ~clk;

  core_ex_muldiv #(.XLEN(64), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op), .i_word(word),
    .i_a(a), .i_b(b), .i_mthi(mthi), .i_mtlo(mtlo), .i_read_hilo(read_hilo),
    .i_flush(flush), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done), .o_stall(stall)
  );

  core_ex_muldiv #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(s4_start), .i_op(s4_op), .i_word(s4_word),
    .i_a(s4_a), .i_b(s4_b), .i_mthi(s4_zero), .i_mtlo(s4_zero), .i_read_hilo(s4_zero),
    .i_flush(s4_zero), .o_hi(d4_hi), .o_lo(d4_lo), .o_busy(d4_busy), .o_done(d4_done),
    .o_stall(d4_stall)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          lat;
    int          s;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_hi"}, hi, e.hi);
          if (e.lat > 0) chk({e.name, "_lat"}, 64'(cyc - e.s + 1), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [1:0] o, input logic w,
                       input logic [63:0] aa, input logic [63:0] bb,
                       input logic [63:0] eh, input logic [63:0] el, input int lat);
    exp_t e;
    start = 1'b1; op = o; word = w; a = aa; b = bb;
    @(posedge clk);
    #1;
    e.hi = eh; e.lo = el; e.lat = lat; e.s = cyc; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, n);
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, n);
    end
  endtask

  task automatic run4(input string nm, input logic [1:0] o, input logic w,
                      input logic [63:0] aa, input logic [63:0] bb,
                      input logic [63:0] eh, input logic [63:0] el, input int lat);
    int s;
    int n = 0;
    @(negedge clk);
    s4_start = 1'b1; s4_op = o; s4_word = w; s4_a = aa; s4_b = bb;
    @(posedge clk);
    #1;
    s = cyc;
    @(negedge clk);
    s4_start = 1'b0;
    while (!d4_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (lat > 0) chk({nm, "_lat"}, 64'(cyc - s + 1), 64'(lat));
    chk({nm, "_lo"}, d4_lo, el);
    chk({nm, "_hi"}, d4_hi, eh);
    @(negedge clk);
  endtask

  initial begin
    int d0, n, bad;
    start = 0; word = 0; mthi = 0; mtlo = 0; read_hilo = 0; flush = 0;
    op = 0; a = 0; b = 0;
    s4_start = 0; s4_op = 0; s4_word = 0; s4_a = 0; s4_b = 0;

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 64'h0);
    chk("rst_lo", lo, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("smulw", 2'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 64'd7,
          64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFEB, EO ? 5 : 34);
    wait_idle("smulw");
    issue("sdivd", 2'd2, 1'b0, 64'hFFFFFFFF_FFFFFFF9, 64'd2,
          64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFD, 66);
    wait_idle("sdivd");
    issue("udivw_dz", 2'd3, 1'b1, 64'd5, 64'd0,
          64'd5, 64'hFFFFFFFF_FFFFFFFF, 34);
    wait_idle("udivw_dz");
    issue("sdivw_ovf", 2'd2, 1'b1, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFFFF,
          64'h0, 64'hFFFFFFFF_80000000, 34);
    wait_idle("sdivw_ovf");
    issue("umuld_b3", 2'd1, 1'b0, 64'h12345678_9ABCDEF0, 64'd3,
          64'h0, 64'h369D0369_D0369CD0, EO ? 4 : 66);
    wait_idle("umuld_b3");
    issue("umuld_max", 2'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
          64'hFFFFFFFF_FFFFFFFE, 64'd1, 66);
    wait_idle("umuld_max");
    issue("smuld", 2'd0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'd5,
          64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFB, EO ? 0 : 66);
    wait_idle("smuld");
    issue("udivw", 2'd3, 1'b1, 64'hFFFFFFFF_00000064, 64'd7,
          64'd2, 64'd14, 34);
    wait_idle("udivw");
    issue("sdivw", 2'd2, 1'b1, 64'hFFFFFFFF_FFFFFF9C, 64'd7,
          64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFF2, 34);
    wait_idle("sdivw");
    issue("sdivd_rem", 2'd2, 1'b0, 64'd100, 64'hFFFFFFFF_FFFFFFF9,
          64'd2, 64'hFFFFFFFF_FFFFFFF2, 66);
    wait_idle("sdivd_rem");

    // Back-to-back: second start presented in the done cycle of the first.
    issue("b2b_a", 2'd3, 1'b1, 64'd100, 64'd7, 64'd2, 64'd14, 34);
    wait_done("b2b_a");
    issue("b2b_b", 2'd1, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF,
          64'hFFFFFFFF_FFFFFFFE, 64'd1, 34);
    wait_idle("b2b_b");

    // mthi, then mtlo with a simultaneous start.
    mthi = 1'b1; a = 64'hAAAA_0000_AAAA_0000;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; start = 1'b1; op = 2'd3; a = 64'h5555_1111_5555_1111; b = 64'd1;
    @(posedge clk);
    #1;
    chk("mtlo_start_busy", {63'h0, busy}, 64'h0);
    chk("mtlo_lo", lo, 64'h5555_1111_5555_1111);
    @(negedge clk);
    mtlo = 1'b0; start = 1'b0;
    chk("mthi_hi", hi, 64'hAAAA_0000_AAAA_0000);

    // Flush at the 10th RUN cycle.
    d0 = done_cnt;
    start = 1'b1; op = 2'd2; word = 1'b0; a = 64'd100; b = 64'd3;
    @(negedge clk);
    start = 1'b0;
    chk("flush_busy_run", {63'h0, busy}, 64'h1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    flush = 1'b0;
    // Flush together with start in IDLE.
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 64'd3; b = 64'd3;
    @(posedge clk);
    #1;
    chk("flush_idle_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (80) @(negedge clk);
    chk("flush_no_done", 64'(done_cnt), 64'(d0));
    chk("flush_hi", hi, 64'hAAAA_0000_AAAA_0000);
    chk("flush_lo", lo, 64'h5555_1111_5555_1111);

    // read_hilo and mtlo while busy.
    issue("stall_op", 2'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 64'd7,
          64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFEB, EO ? 5 : 34);
    read_hilo = 1'b1; mtlo = 1'b1; a = 64'hDEAD_BEEF_DEAD_BEEF;
    n = 0; bad = 0;
    while (busy && n < 200) begin
      if (stall !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    chk("stall_while_busy", 64'(bad), 64'h0);
    chk("stall_cycles_seen", 64'(n > 0), 64'h1);
    chk("stall_idle", {63'h0, stall}, 64'h0);
    read_hilo = 1'b0; mtlo = 1'b0;
    wait_idle("stall_op");

    // Reset in the middle of an operation.
    issue("rst_mid", 2'd2, 1'b0, 64'd1000, 64'd3, 64'd1, 64'd333, 66);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rstmid_busy", {63'h0, busy}, 64'h0);
    chk("rstmid_hi", hi, 64'h0);
    chk("rstmid_lo", lo, 64'h0);
    chk("rstmid_stall", {63'h0, stall}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run4("b4_sdivd", 2'd2, 1'b0, 64'hFFFFFFFF_FFFFFFF9, 64'd2,
         64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFD, 18);
    run4("b4_smulw", 2'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 64'd7,
         64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFEB, EO ? 3 : 10);
    run4("b4_udivd_dz", 2'd3, 1'b0, 64'h123, 64'd0,
         64'h123, 64'hFFFFFFFF_FFFFFFFF, 18);
    run4("b4_umuld", 2'd1, 1'b0, 64'h12345678_9ABCDEF0, 64'd3,
         64'h0, 64'h369D0369_D0369CD0, EO ? 3 : 18);

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_ex_muldiv.md
# core_ex_muldiv

Iterative integer multiply/divide unit attached to the execute stage. It implements the signed and unsigned MULT/DIV families in both word (32-bit) and doubleword forms, and owns the architectural HI/LO registers. The unit is parametrised in data width and in bits retired per cycle. It raises a stall toward the pipeline while an operation is in flight, and it aborts cleanly on a pipeline flush.

## Interface
Parameters:
- XLEN, 64: datapath and HI/LO width; legal values 32 and 64.
- BITS_PER_CYCLE, 1: multiplier/quotient bits retired per iteration; legal values 1, 2 and 4.

Ports:
- clock  in  1  : single clock; all state updates on the rising edge.
- reset  in  1  : asynchronous, active-low; clears all state.
- start  in  1  : issue a mul/div operation this cycle.
- op  in  2  : 0 = MUL signed, 1 = MUL unsigned, 2 = DIV signed, 3 = DIV unsigned.
- word  in  1  : 32-bit form; ignored when XLEN = 32.
- a  in  XLEN  : multiplicand or dividend; also the write data for mthi/mtlo.
- b  in  XLEN  : multiplier or divisor.
- mthi  in  1  : write `a` to HI.
- mtlo  in  1  : write `a` to LO.
- read_hilo  in  1  : the EX-stage instruction is MFHI or MFLO.
- flush  in  1  : pipeline flush.
- hi  out  XLEN  : HI register.
- lo  out  XLEN  : LO register.
- busy  out  1  : an operation is in flight (state is not IDLE).
- done  out  1  : one-cycle pulse, asserted the cycle after HI/LO are updated by an operation.
- stall  out  1  : busy & (start | read_hilo | mthi | mtlo).

## Operation
States:
- IDLE: entered from reset. When start & !flush, latch the operation, take operand magnitudes for signed ops, record the result signs, clear the iteration counter, and go to RUN.
- RUN: retire BITS_PER_CYCLE bits per cycle. Multiply is shift-add. Divide is restoring, with BITS_PER_CYCLE subtract stages chained per cycle. After N = W/BITS_PER_CYCLE iterations go to FIX, where W = 32 for word ops and XLEN otherwise.
- FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.

Operand and result rules:
- Word ops use a[31:0] and b[31:0]; signed word ops interpret bit 31 as the sign.
- Word-op results: low 32 bits of each half, sign-extended to XLEN in HI and LO.
- Multiply: HI:LO = full 2W-bit product.
- Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend; the quotient truncates toward zero.
- Divide by zero: LO = all ones in W bits (sign-extended for word ops); HI = dividend in W bits.
- Signed most-negative / -1: LO = most-negative value (wraps); HI = 0.

Pipeline interaction:
- mthi/mtlo while IDLE: write on that edge; takes priority over a simultaneous start, which is ignored.
- start, mthi, mtlo or read_hilo while busy: ignored, and stall is asserted. The pipeline re-presents the instruction.
- flush in RUN or FIX: abort to IDLE on that edge. HI/LO are unchanged and done is not pulsed.
- flush with start in IDLE: start is ignored.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, stall = 0, state IDLE, counter 0.
- Start accepted at edge k: busy = 1 from k; RUN occupies edges k+1..k+N; FIX at edge k+N+1 writes HI/LO; busy = 0 and done = 1 during the following cycle.
- Total latency: N+2 edges from the start edge to HI/LO valid.
- Iteration counts, shown for XLEN = 64, BITS_PER_CYCLE = 1: word ops N = 32, total 34; doubleword ops N = 64, total 66.
- A back-to-back start is accepted in the cycle in which done = 1.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in RUN, a multiply ends early and moves to FIX at the first edge on which the remaining unconsumed multiplier bits are all zero. Divide timing is unchanged.
- MULDIV_EARLY_OUT_EN undefined: every operation takes the fixed N iterations.

## Test plan
- XLEN = 64, BITS_PER_CYCLE = 1, signed word MUL, a = 0xFFFFFFFF_FFFFFFFD (-3), b = 7 → after 34 edges lo = 0xFFFFFFFF_FFFFFFEB, hi = 0xFFFFFFFF_FFFFFFFF, one done pulse.
- Signed doubleword DIV, a = -7, b = 2 → lo = -3, hi = -1, latency 66 edges. Repeat with BITS_PER_CYCLE = 4 → latency 18 edges.
- Unsigned word DIV, a = 5, b = 0 → lo = 0xFFFFFFFF_FFFFFFFF, hi = 5. Signed word DIV, a = 0x80000000, b = -1 → lo = 0xFFFFFFFF_80000000, hi = 0.
- Start, then flush at the 10th RUN cycle → busy drops the next cycle, hi/lo keep their prior values, no done pulse. A flush arriving with a start in IDLE → no operation is started.
- read_hilo and mtlo raised while busy → stall = 1 every cycle until done, and LO is not written. mtlo raised with start in IDLE → LO = a and the unit stays IDLE.
- With MULDIV_EARLY_OUT_EN, unsigned doubleword MUL with b = 3 → done within 4 edges and lo = 3·a. Without the macro, the same operation takes 66 edges.
